// File: rtl/input_action_decoder_if.sv
// Keycode input and frame-aligned action outputs between the SoC keycode PIO and the
// player blocks.
interface input_action_decoder_if #(
  parameter int SLOTS = 6
);
  logic                 frame_clk;
  logic [8*SLOTS-1:0]   keycode;
  logic                 frame_tick;
  logic [3:0]           p1_dir;
  logic [3:0]           p2_dir;
  logic                 p1_jab;
  logic                 p2_jab;
  logic                 p1_busy;
  logic                 p2_busy;

  modport master (
    output frame_clk, keycode,
    input  frame_tick, p1_dir, p2_dir, p1_jab, p2_jab, p1_busy, p2_busy
  );

  modport slave (
    input  frame_clk, keycode,
    output frame_tick, p1_dir, p2_dir, p1_jab, p2_jab, p1_busy, p2_busy
  );
endinterface

// File: rtl/input_action_decoder.sv
// Keycode scanner with frame-aligned direction levels and per-player jab FSMs.
// Optional macro SOCD_NEUTRAL_EN: opposite directions held together cancel to 0.
module input_action_decoder #(
  parameter int JAB_ACTIVE   = 6,
  parameter int JAB_COOLDOWN = 10,
  parameter int SLOTS        = 6
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input_action_decoder_if.slave    bus
);

  localparam int KW    = 8 * SLOTS;
  localparam int CNT_W = 6;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_V     = 8'h19;
  localparam logic [7:0] KEY_O     = 8'h12;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2
  } jab_state_t;

  function automatic logic key_held(input logic [KW-1:0] kc, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      if (code != 8'h00 && kc[8*k +: 8] == code) hit = 1'b1;
    end
    return hit;
  endfunction

  // Direction vectors are {up, left, down, right}: bit3 opposes bit1, bit2 opposes bit0.
  function automatic logic [3:0] socd_filter(input logic [3:0] d);
`ifdef SOCD_NEUTRAL_EN
    return {d[3] & ~d[1], d[2] & ~d[0], d[1] & ~d[3], d[0] & ~d[2]};
`else
    return d;
`endif
  endfunction

  // Stage p0..p2: frame_clk synchronizer, edge detect, keycode capture
  logic            frame_sync_p0;
  logic            frame_sync_p1;
  logic            frame_prev_p2;
  logic            vld_p2;
  logic [KW-1:0]   key_p0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_sync_p0 <= 1'b0;
      frame_sync_p1 <= 1'b0;
      frame_prev_p2 <= 1'b0;
      vld_p2        <= 1'b0;
      key_p0        <= '0;
    end else begin
      frame_sync_p0 <= bus.frame_clk;
      frame_sync_p1 <= frame_sync_p0;
      frame_prev_p2 <= frame_sync_p1;
      vld_p2        <= frame_sync_p1 & ~frame_prev_p2;
      key_p0        <= bus.keycode;
    end
  end

  logic [3:0] p1_held;
  logic [3:0] p2_held;
  logic [1:0] jab_held;

  assign p1_held  = {key_held(key_p0, KEY_W), key_held(key_p0, KEY_A),
                     key_held(key_p0, KEY_S), key_held(key_p0, KEY_D)};
  assign p2_held  = {key_held(key_p0, KEY_UP),   key_held(key_p0, KEY_LEFT),
                     key_held(key_p0, KEY_DOWN), key_held(key_p0, KEY_RIGHT)};
  assign jab_held = {key_held(key_p0, KEY_O), key_held(key_p0, KEY_V)};

  // Stage p3: frame-aligned direction levels
  logic [3:0] p1_dir_p3;
  logic [3:0] p2_dir_p3;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p1_dir_p3 <= '0;
      p2_dir_p3 <= '0;
    end else if (vld_p2) begin
      p1_dir_p3 <= socd_filter(p1_held);
      p2_dir_p3 <= socd_filter(p2_held);
    end
  end

  logic [1:0] jab_w;
  logic [1:0] busy_w;

  for (genvar p = 0; p < 2; p++) begin : g_jab
    jab_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              prev_q;
    logic              jab_q, busy_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        prev_q  <= 1'b0;
        jab_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else if (vld_p2) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        prev_q  <= jab_held[p];
        jab_q   <= (state_d == ACTIVE);
        busy_q  <= (state_d != IDLE);
      end
    end

    // Presses seen during ACTIVE/COOLDOWN only refresh prev_q, so a held key never retriggers.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE: begin
          if (jab_held[p] && !prev_q) begin
            state_d = ACTIVE;
            cnt_d   = CNT_W'(JAB_ACTIVE - 1);
          end
        end
        ACTIVE: begin
          if (cnt_q == '0) begin
            if (JAB_COOLDOWN == 0) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = COOLDOWN;
              cnt_d   = CNT_W'(JAB_COOLDOWN - 1);
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        COOLDOWN: begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign jab_w[p]  = jab_q;
    assign busy_w[p] = busy_q;
  end

  assign bus.frame_tick = vld_p2;
  assign bus.p1_dir     = p1_dir_p3;
  assign bus.p2_dir     = p2_dir_p3;
  assign bus.p1_jab     = jab_w[0];
  assign bus.p2_jab     = jab_w[1];
  assign bus.p1_busy    = busy_w[0];
  assign bus.p2_busy    = busy_w[1];

endmodule
